// File: rtl/nios_sys_pio_out_if.sv
// nios_sys_pio_out_if: Avalon-MM slave bus carrying register accesses to the output PIO
interface nios_sys_pio_out_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output address, chipselect, write_n, writedata, input readdata);
  modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_sys_pio_out.sv
// nios_sys_pio_out: Avalon-MM output PIO with one-shot pulse engine; define NIOS_SYS_PIO_OUT_BITSET_EN to enable OUTSET/OUTCLEAR
module nios_sys_pio_out #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int PULSE_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  nios_sys_pio_out_if.slave  bus,
  output logic [WIDTH-1:0]   out_port
);
  typedef enum logic {IDLE, PULSE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] data, data_n, mask, mask_n, m;
  logic [PULSE_W-1:0] len, len_n, cnt, cnt_n;
  logic [31:0] rd_n;
  logic wr, trig;
  logic unused;
  assign unused = ^bus.writedata;
  assign m = bus.writedata[WIDTH-1:0];
  assign wr = bus.chipselect && !bus.write_n;
  assign trig = wr && bus.address == 3'd3 && len != '0;
  assign out_port = data;
  // register writes first, then the pulse engine: trigger/retrigger reloads, otherwise count down and clear on expiry
  always_comb begin
    data_n = data;
    mask_n = mask;
    len_n = len;
    cnt_n = cnt;
    state_n = state;
    if (wr)
      case (bus.address)
        3'd0: data_n = m;
        3'd2: len_n = bus.writedata[PULSE_W-1:0];
`ifdef NIOS_SYS_PIO_OUT_BITSET_EN
        3'd4: data_n = data | m;
        3'd5: begin
          data_n = data & ~m;
          mask_n = mask & ~m;
        end
`endif
        default: ;
      endcase
    if (trig) begin
      data_n = data | m;
      mask_n = mask | m;
      cnt_n = len;
      state_n = PULSE;
    end else if (state == PULSE) begin
      cnt_n = cnt - PULSE_W'(1);
      if (cnt == PULSE_W'(1)) begin
        data_n = data_n & ~mask_n;
        mask_n = '0;
        state_n = IDLE;
      end
    end
  end
  // readback mux, sampled every clock regardless of chipselect
  always_comb rd_n = bus.address == 3'd0 ? 32'(data) : bus.address == 3'd2 ? 32'(len) : bus.address == 3'd3 ? 32'(mask) : '0;
  // state and register update with asynchronous abort of any running pulse
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      data <= RESET_VALUE;
      mask <= '0;
      len <= '0;
      cnt <= '0;
      bus.readdata <= '0;
    end else begin
      state <= state_n;
      data <= data_n;
      mask <= mask_n;
      len <= len_n;
      cnt <= cnt_n;
      bus.readdata <= rd_n;
    end
endmodule

// File: tb/tb_nios_sys_pio_out.sv
// tb_nios_sys_pio_out: scoreboard bench with a deadline-based reference model of the output PIO
module tb_nios_sys_pio_out;
  localparam int W = 8;
  localparam int PW = 6;
  localparam logic [7:0] RV = 8'h5A;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [7:0] out_port;
  nios_sys_pio_out_if bus();
  nios_sys_pio_out #(.WIDTH(W), .RESET_VALUE(RV), .PULSE_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .out_port(out_port));
  always #5 clk = ~clk;
  typedef struct {logic [7:0] o; logic [31:0] rd; string tag;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  logic [7:0] m_data, m_mask;
  logic [PW-1:0] m_len;
  bit m_act;
  int m_exp, m_edge;
  string tag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_data = RV;
    m_mask = '0;
    m_len = '0;
    m_act = 0;
  endtask

  // one bus cycle: model the edge (write first, then any pulse deadline reached), queue the expectation
  task automatic cyc(input logic [2:0] a, input bit cs, input bit wn, input logic [31:0] d);
    exp_t e;
    logic [7:0] mm;
    bus.address = a;
    bus.chipselect = cs;
    bus.write_n = wn;
    bus.writedata = d;
    m_edge++;
    e.rd = a == 0 ? 32'(m_data) : a == 2 ? 32'(m_len) : a == 3 ? 32'(m_mask) : 32'd0;
    mm = d[7:0];
    if (cs && !wn)
      case (a)
        3'd0: m_data = mm;
        3'd2: m_len = d[PW-1:0];
        3'd3: if (m_len != 0) begin
          m_data |= mm;
          m_mask |= mm;
          m_act = 1;
          m_exp = m_edge + int'(m_len);
        end
`ifdef NIOS_SYS_PIO_OUT_BITSET_EN
        3'd4: m_data |= mm;
        3'd5: begin
          m_data &= ~mm;
          m_mask &= ~mm;
        end
`endif
        default: ;
      endcase
    if (m_act && m_edge == m_exp) begin
      m_data &= ~m_mask;
      m_mask = '0;
      m_act = 0;
    end
    e.o = m_data;
    e.tag = tag;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(a, 1'b1, 1'b0, d);
  endtask

  task automatic rd(input logic [2:0] a);
    cyc(a, 1'($urandom_range(0, 1)), 1'b1, $urandom);
  endtask

  // monitor: every falling edge the DUT presents out_port/readdata for the preceding rising edge
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, ".out_port"}, 32'(out_port), 32'(e.o));
      chk({e.tag, ".readdata"}, bus.readdata, e.rd);
    end

  initial begin
    bus.address = '0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = '0;
    reset_n = 1'b0;
    #1;
    chk("reset.out_port", 32'(out_port), 32'(RV));
    chk("reset.readdata", bus.readdata, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_hold.out_port", 32'(out_port), 32'(RV));
    reset_n = 1'b1;
    model_reset();
    m_edge = 0;
    tag = "rst_rd";
    rd(0);
    tag = "data";
    wr(0, 32'h1C3);
    rd(0); rd(1); rd(6); rd(7); rd(0);
    tag = "pulse5";
    wr(0, 0); wr(2, 5); wr(3, 1);
    repeat (8) rd(3);
    tag = "retrig";
    wr(2, 4); wr(3, 1); rd(3); wr(3, 2);
    repeat (7) rd(3);
    tag = "setclr";
    wr(2, 8); wr(3, 3); wr(5, 1); rd(3); wr(4, 32'h80);
    repeat (10) rd(3);
    rd(0);
    tag = "len0";
    wr(0, 0); wr(2, 0); wr(3, 32'hFF); rd(0); rd(3); rd(2);
    tag = "lenwr";
    wr(2, 6); wr(3, 4); wr(2, 2);
    repeat (8) rd(0);
    tag = "datawr";
    wr(2, 5); wr(3, 32'h20); wr(0, 32'hF0);
    repeat (6) rd(0);
    tag = "max";
    wr(0, 0); wr(2, 63); rd(2); wr(3, 32'h10);
    repeat (66) rd(3);
    tag = "random";
    repeat (500) begin
      logic [2:0] a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd2) d = 32'($urandom_range(0, 7));
      cyc(a, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, d);
    end
    tag = "rst_mid";
    wr(2, 10); wr(3, 32'h81); rd(0); rd(3);
    reset_n = 1'b0;
    #1;
    chk("rst_mid.out_port", 32'(out_port), 32'(RV));
    chk("rst_mid.readdata", bus.readdata, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    rd(3); rd(2);
    repeat (12) rd(0);
    chk("drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/nios_sys_pio_out.md
Name: nios_sys_pio_out

Overview:
Avalon-MM slave output PIO: the write-side counterpart of the system's read-only input PIO. Drives motor/LED control lines to the LegoCar hardware.
- Holds an output data register with a fixed 1-cycle registered readback.
- Adds a hardware one-shot pulse engine that raises selected bits for a programmed number of clocks, then auto-clears them, so software needs no timing loops.

Parameters:
WIDTH, 8, number of out_port bits (1..32)
RESET_VALUE, 0, out_port/data register value after reset
PULSE_W, 16, width of pulse-length register and countdown counter

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  3  register word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe; write occurs when chipselect=1 and write_n=0
writedata  input  32  write data
readdata  output  32  registered read data
out_port  output  WIDTH  external output lines (= data register)

Behaviour:
- Reset: reset_n is asynchronous, active-low; clk is the clock.
  - Values during reset: data=RESET_VALUE, out_port=RESET_VALUE, readdata=0, pulse_len=0, pulse_mask=0, cnt=0, state=IDLE.
  - Reset asserted mid-pulse aborts the pulse immediately and applies the values above.
- Register map (word address):
  - 0 DATA: RW, bits [WIDTH-1:0].
  - 1: reserved; reads 0, writes ignored.
  - 2 PULSE_LEN: RW, bits [PULSE_W-1:0].
  - 3 TRIGGER: write mask M, starts a pulse; read returns pulse_mask.
  - 4 OUTSET: write-only; data |= M.
  - 5 OUTCLEAR: write-only; data &= ~M.
  - 6, 7: read 0, writes ignored.
  - Unused upper bits read 0. M = writedata[WIDTH-1:0].
- Read: readdata is updated every clock from the address mux, with no read strobe. Latency is 1 clock. chipselect is not needed for reads.
- Write: takes effect on the clk edge where chipselect=1 and write_n=0. out_port reflects the new data on that same edge.
- Pulse FSM, states IDLE and PULSE:
  - IDLE, TRIGGER write with pulse_len!=0: data |= M; pulse_mask <= M; cnt <= pulse_len; go to PULSE.
  - IDLE, TRIGGER write with pulse_len==0: no effect.
  - PULSE, each clock: cnt decrements. When cnt==1 at an edge: data &= ~pulse_mask; pulse_mask <= 0; go to IDLE.
  - Result: the bits are high for exactly pulse_len clocks (set at edge k, cleared at edge k+pulse_len).
  - Retrigger in PULSE (pulse_len!=0): pulse_mask <= pulse_mask | M; data |= M; cnt reloads pulse_len. All masked bits clear together at the new expiry.
- Simultaneous events and boundaries:
  - DATA write during PULSE: written value is applied. Bits still in pulse_mask are cleared at expiry.
  - OUTCLEAR during PULSE: clears data bits and also removes those bits from pulse_mask.
  - OUTSET during PULSE: sets data only; pulse_mask is unchanged.
  - Only one write per clock, since there is a single slave port. The expiry clear and a write on the same edge: write is applied first, then the expiry clear is applied to its result.
  - PULSE_LEN write during PULSE does not affect the running count.
  - PULSE_LEN = 2^PULSE_W-1 is the maximum. cnt must never wrap.

Optional Feature:
NIOS_SYS_PIO_OUT_BITSET_EN
- Defined: OUTSET/OUTCLEAR (addresses 4, 5) are implemented as described.
- Undefined: addresses 4 and 5 behave as reserved (writes ignored, read 0). Software must then use read-modify-write on DATA.

Test Plan:
- Reset with WIDTH=8, RESET_VALUE=8'h5A -> out_port=5A and readdata=0 during reset. After release, address=0 gives readdata=0000005A one clock later.
- Write DATA=0x1C3 (WIDTH=8) -> out_port=C3 on the write edge. Readback at address 0 = 000000C3. Address 1/6/7 read 0.
- PULSE_LEN=5, TRIGGER=0x01 from data=0x00 -> out_port[0]=1 for exactly 5 clocks, then 0. TRIGGER readback shows 01 during the pulse and 00 after.
- PULSE_LEN=4, TRIGGER=0x01, then TRIGGER=0x02 two clocks later -> both bits high; both clear 4 clocks after the second trigger. Total bit-0 high time = 6 clocks.
- During pulse of mask 0x03: OUTCLEAR=0x01 -> bit0 drops immediately, pulse_mask=02. OUTSET=0x80 -> bit7 set and remains 1 after expiry. With BITSET_EN undefined -> both writes have no effect.
- PULSE_LEN=0, TRIGGER=0xFF -> no change to out_port. Assert reset_n low mid-pulse (PULSE_LEN=10) -> out_port=RESET_VALUE immediately, FSM IDLE, pulse_mask=0.
